ps2_kbd_tx: RTL and testbench
=============================

PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50: ps2_clk half-period in clk cycles, legal range 2..65535.
REQ-002 The block SHALL have parameter GAP_CYC, default 100: idle-high clk cycles after every byte, legal range 1..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port key_valid, input, 1 bit: a key event is offered.
REQ-006 The block SHALL have port key_ready, output, 1 bit: a key event can be accepted.
REQ-007 The block SHALL have port key_code, input, 8 bits: scan code of the event.
REQ-008 The block SHALL have port key_release, input, 1 bit: 1 means a break event, 0 means a make event.
REQ-009 The block SHALL have port key_ext, input, 1 bit: extended-key flag, used only under PS2_TX_EXT_EN.
REQ-010 The block SHALL have port ps2_clk, output, 1 bit: device-generated PS/2 clock, idle high.
REQ-011 The block SHALL have port ps2_data, output, 1 bit: PS/2 serial data, idle high.
REQ-012 The block SHALL have port busy, output, 1 bit: a sequence is in progress.

Function
REQ-013 An event SHALL be accepted on a rising clk edge where key_valid=1 and key_ready=1; key_code, key_release and key_ext SHALL be captured on that edge.
REQ-014 key_ready SHALL be 1 only in state IDLE; busy SHALL be the inverse of key_ready.
REQ-015 Byte sequences:
- make event: key_code.
- break event: 8'hF0, then key_code.
REQ-016 The FSM SHALL have states IDLE, PREFIX_EXT, PREFIX_BRK, CODE and GAP.
- IDLE -> PREFIX_EXT on accept when extended; otherwise -> PREFIX_BRK on accept when break; otherwise -> CODE.
- PREFIX_EXT -> GAP -> (PREFIX_BRK if break, else CODE).
- PREFIX_BRK -> GAP -> CODE.
- CODE -> GAP -> IDLE.
REQ-017 Each byte SHALL be sent as an 11-bit frame: start 0, data[0..7] LSB first, odd parity (~^data), stop 1.
REQ-018 Each bit SHALL occupy 2*CLK_DIV cycles: ps2_data set on entry with ps2_clk high for CLK_DIV cycles, then ps2_clk low for CLK_DIV cycles; ps2_data SHALL only change while ps2_clk is high.
REQ-019 The start bit SHALL be driven on the first cycle after acceptance (latency 1), and a frame SHALL last exactly 22*CLK_DIV cycles.
REQ-020 GAP SHALL hold ps2_clk=1 and ps2_data=1 for exactly GAP_CYC cycles.
REQ-021 A make sequence SHALL return to IDLE exactly 22*CLK_DIV+GAP_CYC cycles after acceptance.
REQ-022 key_valid asserted while busy SHALL be ignored (not lost): the event is accepted on the first cycle back in IDLE if still asserted.
REQ-023 Bit and divider counters SHALL be sized $clog2 of their maximum and SHALL reload to 0, never wrap.
REQ-024 ps2_clk and ps2_data SHALL be driven directly from flops, glitch-free.

Reset
REQ-025 While rst=0, state SHALL be IDLE, ps2_clk=1, ps2_data=1, busy=0, key_ready=1, and all counters 0.
REQ-026 Reset asserted mid-frame SHALL abort immediately with no partial frame resumption; the first accept after release starts a fresh sequence.

Configuration
REQ-027 With macro PS2_TX_EXT_EN defined, key_ext=1 SHALL prefix 8'hE0, giving E0,code for make and E0,F0,code for break.
REQ-028 Without PS2_TX_EXT_EN, key_ext SHALL be ignored, and PREFIX_EXT SHALL be unreachable and optimized out.

Structure
REQ-029 Package ps2_pkg SHALL hold the constants PS2_BRK_CODE=8'hF0 and PS2_EXT_CODE=8'hE0 and the FSM state encoding (one-hot, 5 bits).
REQ-030 Sub-module ps2_frame_ser SHALL serialize one byte per start pulse (inputs start and byte; outputs done, ps2_clk, ps2_data), with ps2_kbd_tx sequencing bytes around it.

Verification
REQ-031 Make event: CLK_DIV=4, make 8'h1C -> frame bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0), 88 cycles; IDLE after 88+GAP_CYC cycles.
REQ-032 Break event: break 8'h1C -> frame F0 (parity 1), gap, frame 1C; a receiver-side decoder reports F0 then 1C.
REQ-033 Extended event: with PS2_TX_EXT_EN, extended break 8'h75 -> E0, F0, 75. Without the macro -> F0, 75.
REQ-034 Back-to-back events: key_valid held high with two events -> the second is accepted exactly on the first IDLE cycle, and no byte is dropped.
REQ-035 Mid-frame reset: rst pulsed low at bit 4 -> ps2_clk=1, ps2_data=1 within the same cycle; the next make 8'h29 transmits cleanly.
REQ-036 Timing check: ps2_data never toggles while ps2_clk=0, and each low phase lasts exactly CLK_DIV cycles.

Source files
------------

// File: rtl/ps2_kbd_tx_pkg.sv
// ps2_pkg: PS/2 keyboard transmitter constants, one-hot FSM states, helpers.
// No ports; imported by ps2_frame_ser and ps2_kbd_tx.
package ps2_pkg;

  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;

  typedef enum logic [4:0] {
    S_IDLE       = 5'b00001,
    S_PREFIX_EXT = 5'b00010,
    S_PREFIX_BRK = 5'b00100,
    S_CODE       = 5'b01000,
    S_GAP        = 5'b10000
  } state_t;

  // Width for a counter that runs 0..n-1; at least one bit.
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Wire-order frame, bit 0 first: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Key-event valid/ready handshake between the key source and ps2_kbd_tx.
// Signals: key_valid, key_ready, key_code[7:0], key_release, key_ext.
interface ps2_kbd_tx_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_ext;

  modport master (
    output key_valid, key_code, key_release, key_ext,
    input  key_ready
  );

  modport slave (
    input  key_valid, key_code, key_release, key_ext,
    output key_ready
  );
endinterface

// File: rtl/ps2_frame_ser.sv
// ps2_frame_ser: sends one 11-bit PS/2 frame per i_start pulse.
// Ports: clk, rst (async, active-low), i_start, i_byte -> o_done, o_ps2_clk, o_ps2_data.
module ps2_frame_ser
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_done,
  output logic       o_ps2_clk,
  output logic       o_ps2_data
);

  localparam int DW = cnt_w(CLK_DIV);

  logic [DW-1:0] r_div;
  logic [3:0]    r_bit;
  logic [10:0]   r_frame;
  logic          r_busy;
  logic          r_low;
  logic          r_clk;
  logic          r_data;

  logic w_div_end;
  logic w_last;

  assign w_div_end = (r_div == DW'(CLK_DIV - 1));
  assign w_last    = (r_bit == 4'd10);

  // Asserted in the final low-phase cycle of the stop bit.
  assign o_done = r_busy & r_low & w_div_end & w_last;

  assign o_ps2_clk  = r_clk;
  assign o_ps2_data = r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_frame <= '1;
      r_busy  <= 1'b0;
      r_low   <= 1'b0;
      r_clk   <= 1'b1;
      r_data  <= 1'b1;
    end else if (i_start) begin
      r_frame <= frame_of(i_byte);
      r_div   <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b1;
      r_low   <= 1'b0;
      r_clk   <= 1'b1;
      r_data  <= 1'b0;
    end else if (r_busy) begin
      if (!w_div_end) begin
        r_div <= r_div + DW'(1);
      end else begin
        r_div <= '0;
        if (!r_low) begin
          r_low <= 1'b1;
          r_clk <= 1'b0;
        end else begin
          r_low <= 1'b0;
          r_clk <= 1'b1;
          // Data moves only together with the rising clock edge.
          if (w_last) begin
            r_busy <= 1'b0;
            r_bit  <= '0;
            r_data <= 1'b1;
          end else begin
            r_bit   <= r_bit + 4'd1;
            r_frame <= {1'b1, r_frame[10:1]};
            r_data  <= r_frame[1];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: turns key events into PS/2 make/break byte sequences.
// Ports: clk, rst (async, active-low), kbd (slave), ps2_clk, ps2_data, busy.
// Macro PS2_TX_EXT_EN: key_ext adds the E0 prefix.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int GAP_CYC = 100
) (
  input  logic         clk,
  input  logic         rst,
  ps2_kbd_tx_if.slave  kbd,
  output logic         ps2_clk,
  output logic         ps2_data,
  output logic         busy
);

  localparam int GW = cnt_w(GAP_CYC);

  state_t        r_state;
  state_t        w_next;
  state_t        r_sent;
  logic [7:0]    r_code;
  logic          r_brk;
  logic [GW-1:0] r_gap;

  logic       w_start;
  logic [7:0] w_byte;
  logic       w_done;
  logic       w_gap_end;
  logic       w_ext_in;

`ifdef PS2_TX_EXT_EN
  assign w_ext_in = kbd.key_ext;
`else
  assign w_ext_in = 1'b0;
`endif

  assign kbd.key_ready = (r_state == S_IDLE);
  assign busy          = ~kbd.key_ready;
  assign w_gap_end     = (r_gap == GW'(GAP_CYC - 1));

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_byte  = r_code;
    unique case (r_state)
      S_IDLE: begin
        if (kbd.key_valid) begin
          w_start = 1'b1;
          if (w_ext_in) begin
            w_next = S_PREFIX_EXT;
            w_byte = PS2_EXT_CODE;
          end else if (kbd.key_release) begin
            w_next = S_PREFIX_BRK;
            w_byte = PS2_BRK_CODE;
          end else begin
            w_next = S_CODE;
            w_byte = kbd.key_code;
          end
        end
      end
      S_PREFIX_EXT, S_PREFIX_BRK, S_CODE: begin
        if (w_done) w_next = S_GAP;
      end
      S_GAP: begin
        // r_sent names the byte that preceded this gap.
        if (w_gap_end) begin
          unique case (1'b1)
            (r_sent == S_CODE): begin
              w_next = S_IDLE;
            end
            (r_sent == S_PREFIX_EXT) && r_brk: begin
              w_next  = S_PREFIX_BRK;
              w_start = 1'b1;
              w_byte  = PS2_BRK_CODE;
            end
            default: begin
              w_next  = S_CODE;
              w_start = 1'b1;
              w_byte  = r_code;
            end
          endcase
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sent  <= S_IDLE;
      r_code  <= '0;
      r_brk   <= 1'b0;
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != S_GAP) r_sent <= r_state;
      if (r_state == S_IDLE && kbd.key_valid) begin
        r_code <= kbd.key_code;
        r_brk  <= kbd.key_release;
      end
      if (r_state == S_GAP && !w_gap_end) r_gap <= r_gap + GW'(1);
      else                                r_gap <= '0;
    end
  end

  ps2_frame_ser #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_byte     (w_byte),
    .o_done     (w_done),
    .o_ps2_clk  (ps2_clk),
    .o_ps2_data (ps2_data)
  );

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: directed + random key events, PS/2 receiver-side decoder.
// Checks byte sequences, frame format, timing and handshake latency.
module tb_ps2_kbd_tx;

  localparam int CD = 4;
  localparam int GC = 10;
  localparam int BYTE_CYC = 22 * CD + GC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk, ps2_data, busy;

  ps2_kbd_tx_if kbd ();

  ps2_kbd_tx #(
    .CLK_DIV (CD),
    .GAP_CYC (GC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .kbd      (kbd.slave),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx_q[$];
  logic [10:0] fr_q[$];
  logic [7:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver: samples data on each falling ps2_clk, watches line timing.
  logic        pc_q = 1'b1;
  logic        pd_q = 1'b1;
  int          nb = 0;
  int          lowc = 0;
  logic [10:0] sh = '0;

  always @(negedge clk) begin
    if (!rst) begin
      nb = 0;
      lowc = 0;
    end else begin
      if (pc_q && !ps2_clk) begin
        sh = {ps2_data, sh[10:1]};
        nb++;
        if (nb == 11) begin
          chk("frame_start", sh[0], 1'b0);
          chk("frame_stop", sh[10], 1'b1);
          chk("frame_parity", sh[9], ~^sh[8:1]);
          rx_q.push_back(sh[8:1]);
          fr_q.push_back(sh);
          nb = 0;
        end
      end
      if (!ps2_clk) lowc++;
      if (!pc_q && !ps2_clk) chk("data_moved_while_low", ps2_data, pd_q);
      if (!pc_q && ps2_clk) begin
        chk("low_phase_len", lowc, CD);
        lowc = 0;
      end
    end
    pc_q = ps2_clk;
    pd_q = ps2_data;
  end

  // Reference: byte list for one key event.
  task automatic model(input logic [7:0] c, input logic rel, input logic ext);
`ifdef PS2_TX_EXT_EN
    if (ext) exp_q.push_back(8'hE0);
`else
    if (ext) begin end
`endif
    if (rel) exp_q.push_back(8'hF0);
    exp_q.push_back(c);
  endtask

  task automatic offer(input logic [7:0] c, input logic rel, input logic ext);
    int k;
    k = 0;
    @(negedge clk);
    while (!kbd.key_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_offer", kbd.key_ready, 1'b1);
    kbd.key_code = c;
    kbd.key_release = rel;
    kbd.key_ext = ext;
    kbd.key_valid = 1'b1;
    @(posedge clk);
    #1;
    kbd.key_valid = 1'b0;
    chk("start_bit_latency", ps2_data, 1'b0);
    chk("start_bit_clk_high", ps2_clk, 1'b1);
    chk("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_idle(input int exp_cyc, input string tag);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!kbd.key_ready && k < 20000);
    chk(tag, k, exp_cyc);
  endtask

  task automatic check_rx(input string tag);
    int n;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
    fr_q.delete();
  endtask

  initial begin
    logic [7:0] c;
    logic       rel, ext, rdy;
    int         n0, na, nbb, k;

    kbd.key_valid = 1'b0;
    kbd.key_code = '0;
    kbd.key_release = 1'b0;
    kbd.key_ext = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ps2_clk", ps2_clk, 1'b1);
    chk("rst_ps2_data", ps2_data, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", kbd.key_ready, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;

    // Make 1C: exact frame bits and timing.
    model(8'h1C, 1'b0, 1'b0);
    offer(8'h1C, 1'b0, 1'b0);
    wait_idle(BYTE_CYC, "make_idle_cycles");
    chk("make_frame_count", fr_q.size(), 1);
    if (fr_q.size() > 0) chk("make_frame_bits", fr_q[0], 11'h438);
    check_rx("make");

    // Break 1C.
    model(8'h1C, 1'b1, 1'b0);
    offer(8'h1C, 1'b1, 1'b0);
    wait_idle(2 * BYTE_CYC, "break_idle_cycles");
    check_rx("break");

    // Extended break 75.
    n0 = exp_q.size();
    model(8'h75, 1'b1, 1'b1);
    offer(8'h75, 1'b1, 1'b1);
    wait_idle((exp_q.size() - n0) * BYTE_CYC, "ext_idle_cycles");
    check_rx("ext_break");

    // Random events.
    for (int i = 0; i < 10; i++) begin
      c = 8'($urandom);
      rel = 1'($urandom_range(0, 1));
      ext = 1'($urandom_range(0, 1));
      n0 = exp_q.size();
      model(c, rel, ext);
      offer(c, rel, ext);
      wait_idle((exp_q.size() - n0) * BYTE_CYC, "rand_idle_cycles");
      check_rx("rand");
    end

    // Back-to-back with key_valid held high.
    model(8'h2B, 1'b1, 1'b0);
    na = exp_q.size();
    model(8'h33, 1'b0, 1'b1);
    nbb = exp_q.size() - na;
    @(negedge clk);
    kbd.key_code = 8'h2B;
    kbd.key_release = 1'b1;
    kbd.key_ext = 1'b0;
    kbd.key_valid = 1'b1;
    @(posedge clk);
    #1;
    kbd.key_code = 8'h33;
    kbd.key_release = 1'b0;
    kbd.key_ext = 1'b1;
    k = 0;
    rdy = 1'b0;
    while (!rdy && k < 20000) begin
      @(negedge clk);
      rdy = kbd.key_ready;
      @(posedge clk);
      k++;
    end
    #1;
    kbd.key_valid = 1'b0;
    chk("b2b_accept_cycle", k, na * BYTE_CYC + 1);
    chk("b2b_second_start", ps2_data, 1'b0);
    wait_idle(nbb * BYTE_CYC, "b2b_idle_cycles");
    check_rx("b2b");

    // Reset in the middle of a frame.
    offer(8'h5A, 1'b0, 1'b0);
    k = 0;
    while (nb < 4 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_reached_bit4", nb >= 4, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ps2_clk", ps2_clk, 1'b1);
    chk("midrst_ps2_data", ps2_data, 1'b1);
    chk("midrst_ready", kbd.key_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    chk("midrst_no_bytes", rx_q.size(), 0);
    rx_q.delete();
    exp_q.delete();
    fr_q.delete();
    model(8'h29, 1'b0, 1'b0);
    offer(8'h29, 1'b0, 1'b0);
    wait_idle(BYTE_CYC, "after_rst_idle_cycles");
    check_rx("after_rst");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
